// File: rtl/fp_res_collector.sv
// Result collector for the pipelined float32 adder: FWFT FIFO on the result stream,
// issue-side credit so no in-flight result can overflow it, and post-reset blanking.
module fp_res_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LAT   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue,
  output logic                         can_issue,
  input  logic                         in_val,
  input  logic [31:0]                  in_res,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_nan,
  output logic                         out_inf,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_proto
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned BW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] INFL_MAX = '1;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          err_q, err_d;

  logic          blanking, full, pop, push, in_live;
  logic [CW:0]   used;
  logic [CW:0]   infl_sum;

  assign blanking  = (blank_q != BW'(LAT));
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = (count_q != '0) && out_ready;
  // results arriving during blanking belong to pre-reset issues and are discarded
  assign in_live   = in_val && !blanking;
  assign push      = in_live && (!full || pop);
  assign used      = {1'b0, count_q} + {1'b0, infl_q};
  assign can_issue = !blanking && (used < (CW+1)'(DEPTH));

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_nan   = (out_data[30:23] == 8'hFF) && (out_data[22:0] != '0);
  assign out_inf   = (out_data[30:23] == 8'hFF) && (out_data[22:0] == '0);
  assign count     = count_q;
  assign err_proto = err_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    blank_d  = blank_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_res;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // floor at zero on unexpected results, ceiling on runaway illegal issues
    infl_sum = {1'b0, infl_q} + (CW+1)'(issue) - (CW+1)'(in_live && (infl_q != '0));
    infl_d   = (infl_sum > {1'b0, INFL_MAX}) ? INFL_MAX : infl_sum[CW-1:0];

    err_d = err_q
          | (issue && !can_issue)
          | (in_live && !push)
          | (in_live && (infl_q == '0));

    if (blanking) begin
      blank_d = blank_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      blank_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fp_res_collector.sv
// Self-checking bench for fp_res_collector: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fp_res_collector;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned LAT      = 3;
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int          INFL_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue = 1'b0;
  logic          in_val = 1'b0;
  logic [31:0]   in_res = '0;
  logic          out_ready = 1'b0;
  logic          can_issue, out_valid, out_nan, out_inf, err_proto;
  logic [31:0]   out_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fp_res_collector #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .can_issue(can_issue),
    .in_val   (in_val),
    .in_res   (in_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_nan  (out_nan),
    .out_inf  (out_inf),
    .count    (count),
    .err_proto(err_proto)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, credits as plain integers.
  logic [31:0] mq[$];
  int          m_infl  = 0;
  int          m_blank = 0;
  bit          m_err   = 0;
  bit          started = 0;
  bit          m_blk, m_can, m_pop, m_live;

  function automatic bit exp_can_issue();
    return (m_blank >= LAT) && ((mq.size() + m_infl) < DEPTH);
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      mq.delete();
      m_infl  = 0;
      m_blank = 0;
      m_err   = 0;
    end else begin
      m_blk  = (m_blank < LAT);
      m_can  = exp_can_issue();
      m_pop  = (mq.size() != 0) && out_ready;
      m_live = in_val && !m_blk;
      if (issue && !m_can) m_err = 1;
      if (m_live && m_infl == 0) m_err = 1;
      if (m_pop) void'(mq.pop_front());
      if (m_live) begin
        if (mq.size() < DEPTH) mq.push_back(in_res);
        else m_err = 1;
      end
      m_infl = m_infl + int'(issue) - ((m_live && m_infl > 0) ? 1 : 0);
      if (m_infl > INFL_MAX) m_infl = INFL_MAX;
      if (m_blk) m_blank++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("can_issue", 32'(can_issue), 32'(exp_can_issue()));
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("err_proto", 32'(err_proto), 32'(m_err));
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0]);
        chk("out_nan", 32'(out_nan), 32'(((mq[0] >> 23) & 32'hFF) == 32'hFF && (mq[0] & 32'h7FFFFF) != 0));
        chk("out_inf", 32'(out_inf), 32'(((mq[0] >> 23) & 32'hFF) == 32'hFF && (mq[0] & 32'h7FFFFF) == 0));
      end
    end
  end

  // Adder emulation: an issue in cycle c yields in_val in cycle c+LAT.
  bit          ring_v [64];
  logic [31:0] ring_d [64];
  int          cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    issue  = 1'b0;
    in_val = ring_v[cyc % 64];
    in_res = ring_v[cyc % 64] ? ring_d[cyc % 64] : $urandom;
    ring_v[cyc % 64] = 1'b0;
  endtask

  task automatic do_issue(input logic [31:0] d);
    issue = 1'b1;
    ring_v[(cyc + LAT) % 64] = 1'b1;
    ring_d[(cyc + LAT) % 64] = d;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:0] = {8'hFF, 23'h0};
      1: r[30:23] = 8'hFF;
      default: ;
    endcase
    return r;
  endfunction

  int n;
  int ready_pct;

  initial begin
    // reset and blanking
    do_reset(2);
    chk("rst_can_issue_c0", 32'(can_issue), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick();
    in_val = 1'b1;
    in_res = 32'h3F800000;
    tick();
    chk("blank_no_push", 32'(count), 32'd0);
    chk("blank_no_err", 32'(err_proto), 32'd0);
    chk("blank_can_issue_c2", 32'(can_issue), 32'd0);
    tick();
    chk("can_issue_c3", 32'(can_issue), 32'd1);

    // single op
    out_ready = 1'b1;
    do_issue(32'h40400000);
    repeat (LAT) tick();
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h40400000);
    tick();
    chk("single_count0", 32'(count), 32'd0);

    // credit limit
    out_ready = 1'b0;
    n = 0;
    while (can_issue && n < 20) begin
      do_issue(rand_fp());
      tick();
      n++;
    end
    chk("credit_issues", 32'(n), 32'd8);
    chk("credit_can_issue_low", 32'(can_issue), 32'd0);
    repeat (LAT + 1) tick();
    chk("credit_count8", 32'(count), 32'd8);
    chk("credit_no_err", 32'(err_proto), 32'd0);

    // full: dropped push, then simultaneous push/pop across pointer wrap
    in_val = 1'b1;
    in_res = 32'h11111111;
    tick();
    chk("full_drop_count", 32'(count), 32'd8);
    for (int i = 0; i < 11; i++) begin
      in_val    = 1'b1;
      in_res    = rand_fp();
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("full_pushpop_count", 32'(count), 32'd8);
    chk("full_err", 32'(err_proto), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_count7", 32'(count), 32'd7);
    chk("pop_frees_credit", 32'(can_issue), 32'd1);

    // mid-operation reset clears everything
    do_reset(1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_err", 32'(err_proto), 32'd0);

    // issue while can_issue = 0 (during blanking)
    do_issue(32'h3F800000);
    tick();
    chk("viol_issue_err", 32'(err_proto), 32'd1);
    repeat (5) tick();
    chk("viol_issue_sticky", 32'(err_proto), 32'd1);
    do_reset(1);
    chk("viol_rst_clears", 32'(err_proto), 32'd0);

    // in_val with nothing in flight
    repeat (LAT) tick();
    in_val = 1'b1;
    in_res = 32'h40000000;
    tick();
    chk("viol_inval_err", 32'(err_proto), 32'd1);
    chk("viol_inval_pushed", 32'(count), 32'd1);
    repeat (4) tick();
    chk("viol_inval_sticky", 32'(err_proto), 32'd1);

    // NaN / Inf flags
    do_reset(1);
    repeat (LAT) tick();
    out_ready = 1'b0;
    do_issue(32'h7FC00000);
    tick();
    do_issue(32'hFF800000);
    tick();
    repeat (LAT) tick();
    chk("flag_nan_data", out_data, 32'h7FC00000);
    chk("flag_nan", 32'(out_nan), 32'd1);
    chk("flag_nan_inf", 32'(out_inf), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("flag_inf_nan", 32'(out_nan), 32'd0);
    chk("flag_inf", 32'(out_inf), 32'd1);

    // randomized traffic with occasional illegal issues and resets
    ready_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ready_pct = 5;
          1: ready_pct = 50;
          default: ready_pct = 95;
        endcase
      end
      rst       = ($urandom_range(0, 599) == 0);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (!rst && ((can_issue && $urandom_range(0, 9) < 6) || $urandom_range(0, 299) == 0))
        do_issue(rand_fp());
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + DEPTH + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_res_collector.md
# fp_res_collector

Result-side companion of the pipelined float32 adder. Captures the adder's `val`/`res` stream, buffers it in a FIFO, and presents it to downstream logic over a valid/ready handshake. The adder has no backpressure, so the block also supplies the issue-side credit (`can_issue`) that guarantees every issued operation finds a free FIFO slot when its result arrives. It sits between the adder output and any stalling consumer.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥ 4.
- `LAT`, 3 — adder latency in cycles, from `en` to `val`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue`  in  1  high in the same cycle the upstream drives adder `en` = 1.
- `can_issue`  out  1  upstream may assert `issue` this cycle.
- `in_val`  in  1  adder `val`.
- `in_res`  in  32  adder `res`.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  32  head entry value.
- `out_nan`  out  1  head entry has exp == 8'hFF and mant != 0.
- `out_inf`  out  1  head entry has exp == 8'hFF and mant == 0.
- `count`  out  $clog2(DEPTH+1)  number of stored entries.
- `err_proto`  out  1  sticky protocol-error flag.

## Operation
- Storage: `DEPTH` × 32 memory, plus `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits. Pointers wrap modulo `DEPTH`.
- Read side is first-word-fall-through:
  - `out_data` = mem[rd_ptr]; `out_nan`/`out_inf` are decoded combinationally from it.
  - `out_valid` = (count != 0).
- Pop: occurs when `out_valid && out_ready`; `rd_ptr`++.
- Push: occurs when `in_val`, not blanking, and (count < DEPTH or pop this cycle); writes `in_res` at `wr_ptr`, then `wr_ptr`++.
- `count` next value = count + push − pop. Push and pop in the same cycle leave `count` unchanged, including when full.
- In-flight counter `infl` (width $clog2(DEPTH+1)):
  - next value = infl + (issue accepted) − (in_val accepted).
  - `issue` is accepted whenever it is high, even if `can_issue` = 0.
- `can_issue` = !blanking && (count + infl < DEPTH), combinational.
- `err_proto` is set (and stays set until `rst`) by any of:
  - `issue` while `can_issue` = 0;
  - `in_val` dropped because the FIFO is full;
  - `in_val` while `infl` == 0 and not blanking. The result is still pushed if space exists; `infl` saturates at 0.
- Post-reset blanking:
  - The adder has no reset, so results issued before `rst` can still emerge.
  - After `rst` deasserts, a `blank_cnt` counts `LAT` cycles.
  - During blanking, `in_val` is ignored (no push, no error) and `can_issue` = 0.
  - Blanking ends when `blank_cnt` reaches `LAT`.

## Timing
- Reset values:
  - `can_issue` = 0 (blanking).
  - `out_valid` = 0, `count` = 0, `err_proto` = 0.
  - `out_data`, `out_nan`, `out_inf` are don't-care while `out_valid` = 0.
  - Pointers = 0, `infl` = 0, `blank_cnt` = 0.
- First `can_issue` = 1 occurs in cycle `LAT` after the last `rst`-high cycle (cycles 0..LAT−1 are blanked).
- Latency: `in_val` at edge N → `out_valid` = 1 and `out_data` = that value in the cycle after edge N. `issue` → `out_valid` is `LAT` + 1 cycles.
- A pop at edge N exposes the next entry immediately after edge N.
- A pop frees a credit in the following cycle; arrival of a result neither frees nor consumes a credit (it moves from `infl` to `count`).
- `rst` mid-operation clears the FIFO, `infl` and `err_proto`. Any results still in flight arrive during blanking and are discarded.
- The credit rule guarantees no overflow under legal use, with `out_ready` = 0 for any duration.

## Test plan
- **Reset/blanking:** hold `rst` 2 cycles, then pulse `in_val` with `in_res` = 32'h3F800000 at cycle 1 after reset.
  - Required: no push, `err_proto` = 0, `can_issue` rises at cycle 3 (LAT = 3).
- **Single op:** `issue` at cycle 10, `in_val` with 32'h40400000 at cycle 13, `out_ready` = 1.
  - Required: `out_valid` = 1 with `out_data` = 32'h40400000 in cycle 14, popped at that edge, `count` back to 0.
- **Credit limit:** `out_ready` = 0, `issue` every cycle while `can_issue` = 1.
  - Required: exactly 8 issues accepted, `can_issue` low after the 8th, `count` = 8 after results land, `err_proto` = 0.
  - Then 1 pop → `can_issue` = 1 the next cycle.
- **Full with simultaneous push/pop:** `count` = 8, `in_val` and `out_ready` in the same cycle.
  - Required: `count` stays 8, FIFO order preserved, `wr_ptr`/`rd_ptr` wrap to 0 correctly.
- **Violations:** `issue` while `can_issue` = 0, and a separate `in_val` with `infl` = 0 after blanking.
  - Required: `err_proto` = 1 and held until `rst`.
- **Flags:** push 32'h7FC00000, then 32'hFF800000.
  - Required: head shows `out_nan` = 1/`out_inf` = 0, then `out_nan` = 0/`out_inf` = 1.
